string_accel_avalon_seq: RTL and testbench

Parametrised, multi-cycle successor to the string hardware accelerator. It is an Avalon-MM slave holding string operand A and string operand B, each MAX_BLOCKS 32-bit words, plus control and result registers. A sequential engine processes LANES bytes per clock. It supports compare, to-upper, to-lower and strlen, with early termination, a busy flag and an illegal-op error flag. Nios II software drives it through the same register-window style as the existing accelerator.

---
 rtl/string_accel_avalon_seq.sv | 205 ++++++++++++++++++++
 tb/tb_string_accel_avalon_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/string_accel_avalon_seq.sv
// Avalon-MM string accelerator: A/B operand windows plus control/result registers,
// with a sequential engine handling LANES bytes per clock (compare, case conversion, strlen).
module string_accel_avalon_seq #(
    parameter int MAX_BLOCKS   = 2,
    parameter int ADDRESS_BITS = 4,
    parameter int LANES        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDRESS_BITS:0] address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata
);
    localparam int NBYTES   = 4 * MAX_BLOCKS;
    localparam int PW       = $clog2(NBYTES + 1);
    localparam int IW       = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
    localparam int ADDR_RES = 2 * MAX_BLOCKS + 1;

    localparam logic [2:0] OP_CMP    = 3'd0;
    localparam logic [2:0] OP_UPPER  = 3'd1;
    localparam logic [2:0] OP_LOWER  = 3'd2;
    localparam logic [2:0] OP_STRLEN = 3'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef logic [MAX_BLOCKS-1:0][31:0] str_t;

    state_t        state_q, state_d;
    str_t          a_q, a_d, b_q, b_d;
    logic [31:0]   result_q, result_d;
    logic [31:0]   readdata_q, readdata_d;
    logic [2:0]    op_q, op_d;
    logic          go_q, go_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [PW-1:0] ptr_q, ptr_d;

    int            addr;
    int            n_byte;
    logic [7:0]    a_byte, b_byte;
    logic          term;
    logic [31:0]   term_res;

    // Byte 0 of a word lives in bits 31:24.
    function automatic logic [7:0] get_byte(input str_t s, input int n);
        logic [31:0] w;
        w = s[IW'(n / 4)];
        return 8'(w >> (8 * (3 - n % 4)));
    endfunction

    function automatic str_t put_byte(input str_t s, input int n, input logic [7:0] v);
        str_t r;
        int   sh;
        r  = s;
        sh = 8 * (3 - n % 4);
        r[IW'(n / 4)] = (s[IW'(n / 4)] & ~(32'hFF << sh)) | (32'(v) << sh);
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        readdata_d = readdata_q;
        op_d       = op_q;
        go_d       = go_q;
        done_d     = done_q;
        busy_d     = busy_q;
        err_d      = err_q;
        ptr_d      = ptr_q;
        addr       = int'(address);
        n_byte     = 0;
        a_byte     = '0;
        b_byte     = '0;
        term       = 1'b0;
        term_res   = '0;

        if (chipselect && read) begin
            if (addr == 0)
                readdata_d = {25'd0, err_q, busy_q, op_q, go_q, done_q};
            else if (addr <= MAX_BLOCKS)
                readdata_d = a_q[IW'(addr - 1)];
            else if (addr <= 2 * MAX_BLOCKS)
                readdata_d = b_q[IW'(addr - 1 - MAX_BLOCKS)];
            else if (addr == ADDR_RES)
                readdata_d = result_q;
            else
                readdata_d = '0;
        end

        // Bus writes are only honoured outside RUN, so they never race the engine.
        if (chipselect && write && state_q != S_RUN) begin
            if (addr == 0) begin
                op_d = writedata[4:2];
                if (writedata[1]) begin
                    go_d   = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    if (writedata[4:2] <= OP_STRLEN) begin
                        busy_d  = 1'b1;
                        ptr_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    go_d = 1'b0;
                    if (state_q == S_DONE) begin
                        done_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end else if (addr <= MAX_BLOCKS) begin
                a_d[IW'(addr - 1)] = writedata;
            end else if (addr <= 2 * MAX_BLOCKS) begin
                b_d[IW'(addr - 1 - MAX_BLOCKS)] = writedata;
            end
        end

        if (state_q == S_RUN) begin
            for (int l = 0; l < LANES; l++) begin
                n_byte = int'(ptr_q) + l;
                a_byte = get_byte(a_q, n_byte);
                b_byte = get_byte(b_q, n_byte);
                case (op_q)
                    OP_UPPER:
                        if (a_byte >= 8'h61 && a_byte <= 8'h7A)
                            a_d = put_byte(a_d, n_byte, a_byte - 8'h20);
                    OP_LOWER:
                        if (a_byte >= 8'h41 && a_byte <= 8'h5A)
                            a_d = put_byte(a_d, n_byte, a_byte + 8'h20);
                    OP_CMP:
                        if (!term) begin
                            if (a_byte != b_byte) begin
                                term     = 1'b1;
                                term_res = 32'd0;
                            end else if (a_byte == 8'h00) begin
                                term     = 1'b1;
                                term_res = 32'd1;
                            end
                        end
                    OP_STRLEN:
                        if (!term && a_byte == 8'h00) begin
                            term     = 1'b1;
                            term_res = 32'(n_byte);
                        end
                    default: ;
                endcase
            end

            if (term || ptr_q == PW'(NBYTES - LANES)) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                if (op_q == OP_CMP)
                    result_d = term ? term_res : 32'd1;
                else if (op_q == OP_STRLEN)
                    result_d = term ? term_res : 32'(NBYTES);
                else
                    result_d = 32'd0;
            end else begin
                ptr_d = ptr_q + PW'(LANES);
            end
        end
    end

    // Operand storage is cleared on reset too, so a reset mid-conversion leaves no partial string.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            readdata_q <= '0;
            op_q       <= '0;
            go_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            readdata_q <= readdata_d;
            op_q       <= op_d;
            go_q       <= go_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_string_accel_avalon_seq.sv
// Randomized + directed bench for string_accel_avalon_seq; a LANES=4 and a LANES=1
// instance are checked against a byte-level reference model.
module tb_string_accel_avalon_seq;
    localparam int MB  = 2;
    localparam int NB  = 4 * MB;
    localparam int AB  = 4;
    localparam int RES = 2 * MB + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    cs;
    logic          read, write;
    logic [AB:0]   address;
    logic [31:0]   writedata;
    logic [31:0]   rd4, rd1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_a [2][MB];
    logic [31:0] m_b [2][MB];
    logic [31:0] m_res [2];
    logic        m_err [2];

    always #5 clk = ~clk;

    string_accel_avalon_seq #(.MAX_BLOCKS(MB), .ADDRESS_BITS(AB), .LANES(4)) dut4 (
        .clk(clk), .reset(reset), .chipselect(cs[0]), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(rd4)
    );

    string_accel_avalon_seq #(.MAX_BLOCKS(MB), .ADDRESS_BITS(AB), .LANES(1)) dut1 (
        .clk(clk), .reset(reset), .chipselect(cs[1]), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(rd1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int d, input int a, input logic [31:0] data);
        cs        = 2'b00;
        cs[d]     = 1'b1;
        write     = 1'b1;
        address   = (AB + 1)'(a);
        writedata = data;
        tick();
        cs        = 2'b00;
        write     = 1'b0;
    endtask

    task automatic bus_read(input int d, input int a, output logic [31:0] data);
        cs      = 2'b00;
        cs[d]   = 1'b1;
        read    = 1'b1;
        address = (AB + 1)'(a);
        tick();
        data    = (d == 0) ? rd4 : rd1;
        cs      = 2'b00;
        read    = 1'b0;
    endtask

    task automatic set_ab(input int d, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] b0, input logic [31:0] b1);
        bus_write(d, 1, a0);
        bus_write(d, 2, a1);
        bus_write(d, 1 + MB, b0);
        bus_write(d, 2 + MB, b1);
        m_a[d][0] = a0; m_a[d][1] = a1;
        m_b[d][0] = b0; m_b[d][1] = b1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < MB; w++) begin
                m_a[d][w] = '0;
                m_b[d][w] = '0;
            end
            m_res[d] = '0;
            m_err[d] = 1'b0;
        end
    endtask

    // Works on the strings as plain byte arrays; lat = clocks until done shows in a control read.
    task automatic model_exec(input int d, input int op, output int lat);
        logic [7:0]  a [NB];
        logic [7:0]  b [NB];
        int          lanes, term;
        logic [31:0] res;
        lanes = (d == 0) ? 4 : 1;
        term  = -1;
        res   = '0;
        if (op > 3) begin
            m_err[d] = 1'b1;
            lat      = 1;
            return;
        end
        for (int i = 0; i < NB; i++) begin
            a[i] = 8'(m_a[d][i / 4] >> (8 * (3 - i % 4)));
            b[i] = 8'(m_b[d][i / 4] >> (8 * (3 - i % 4)));
        end
        case (op)
            0: begin
                res = 32'd1;
                for (int i = 0; i < NB; i++)
                    if (term < 0) begin
                        if (a[i] != b[i]) begin term = i; res = 32'd0; end
                        else if (a[i] == 8'h00) begin term = i; res = 32'd1; end
                    end
            end
            1: for (int i = 0; i < NB; i++) if (a[i] >= "a" && a[i] <= "z") a[i] = a[i] - 8'h20;
            2: for (int i = 0; i < NB; i++) if (a[i] >= "A" && a[i] <= "Z") a[i] = a[i] + 8'h20;
            default: begin
                res = 32'(NB);
                for (int i = 0; i < NB; i++)
                    if (term < 0 && a[i] == 8'h00) begin term = i; res = 32'(i); end
            end
        endcase
        for (int w = 0; w < MB; w++)
            m_a[d][w] = {a[4*w], a[4*w+1], a[4*w+2], a[4*w+3]};
        m_res[d] = res;
        m_err[d] = 1'b0;
        lat = (term < 0) ? (NB / lanes + 1) : (term / lanes + 2);
    endtask

    task automatic do_op(input int d, input int op, output int clocks);
        logic [31:0] v, first_v, exp_ctl;
        int          lat;
        model_exec(d, op, lat);
        exp_ctl = 32'h3 | (32'(op) << 2) | (m_err[d] ? 32'h40 : 32'h0);
        bus_write(d, 0, (32'(op) << 2) | 32'h2);
        clocks  = -1;
        v       = '0;
        first_v = '0;
        for (int k = 1; k <= 40 && clocks < 0; k++) begin
            bus_read(d, 0, v);
            if (k == 1) first_v = v;
            if (v[0]) clocks = k;
        end
        check($sformatf("d%0d_op%0d_latency", d, op), 32'(clocks), 32'(lat));
        if (op <= 3) check($sformatf("d%0d_busy_after_start", d), {31'd0, first_v[5]}, 32'd1);
        check($sformatf("d%0d_ctl_done", d), v, exp_ctl);
        bus_read(d, RES, v);
        check($sformatf("d%0d_result", d), v, m_res[d]);
        for (int w = 0; w < MB; w++) begin
            bus_read(d, 1 + w, v);
            check($sformatf("d%0d_a%0d", d, w), v, m_a[d][w]);
            bus_read(d, 1 + MB + w, v);
            check($sformatf("d%0d_b%0d", d, w), v, m_b[d][w]);
        end
    endtask

    function automatic logic [7:0] rnd_byte();
        case ($urandom_range(0, 4))
            0:       return 8'h61 + 8'($urandom_range(0, 25));
            1:       return 8'h41 + 8'($urandom_range(0, 25));
            2:       return 8'h00;
            3:       return 8'h20;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] w [4];
        int          clocks, d, op;

        cs = 2'b00; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int a = 0; a <= RES; a++) begin
            bus_read(0, a, v);
            check($sformatf("reset_addr%0d", a), v, 32'd0);
        end

        // Equal strings: full scan, result 1.
        set_ab(0, "abcd", "efgh", "abcd", "efgh");
        do_op(0, 0, clocks);
        check("t1_latency", 32'(clocks), 32'd3);
        bus_read(0, 0, v);
        check("t1_ctl", v, 32'h03);

        // Mismatch at byte 4, then go=0 back to IDLE.
        set_ab(0, "abcd", "efgh", "abcd", "abcd");
        do_op(0, 0, clocks);
        check("t2_latency", 32'(clocks), 32'd3);
        bus_read(0, RES, v);
        check("t2_result", v, 32'd0);
        bus_write(0, 0, 32'h0);
        bus_read(0, 0, v);
        check("t2_ctl_idle", v, 32'h00);

        // Shared NUL in group 0 ends the compare early.
        set_ab(0, 32'h61626300, "1111", 32'h61626300, "2222");
        do_op(0, 0, clocks);
        check("t3_latency", 32'(clocks), 32'd2);
        bus_read(0, RES, v);
        check("t3_result", v, 32'd1);

        // to_upper on both lane widths.
        set_ab(0, "AbCd", "Ef  ", 32'h0, 32'h0);
        do_op(0, 1, clocks);
        bus_read(0, 1, v);
        check("t4_a0", v, "ABCD");
        bus_read(0, 2, v);
        check("t4_a1", v, "EF  ");
        set_ab(1, "AbCd", "Ef  ", 32'h0, 32'h0);
        do_op(1, 1, clocks);
        check("t4_lanes1_latency", 32'(clocks), 32'd9);

        // to_lower, strlen, illegal op.
        set_ab(0, "AbCd", "E   ", 32'h0, 32'h0);
        do_op(0, 2, clocks);
        bus_read(0, 1, v);
        check("t5_lower_a0", v, "abcd");
        bus_read(0, 2, v);
        check("t5_lower_a1", v, "e   ");
        set_ab(0, 32'h68656C00, "xxxx", 32'h0, 32'h0);
        do_op(0, 3, clocks);
        bus_read(0, RES, v);
        check("t5_strlen", v, 32'd3);
        do_op(0, 5, clocks);
        bus_read(0, 0, v);
        check("t5_illegal_err_done_busy", v & 32'h61, 32'h41);
        bus_read(0, 1, v);
        check("t5_illegal_a0", v, 32'h68656C00);

        // Result is read-only; unmapped addresses read 0 and ignore writes.
        bus_write(0, RES, 32'hFFFF_FFFF);
        bus_read(0, RES, v);
        check("result_ro", v, 32'd3);
        bus_write(0, RES + 1, 32'h1234_5678);
        bus_read(0, RES + 1, v);
        check("unmapped_read", v, 32'd0);

        // Busy blocks writes; reset mid-RUN clears everything.
        set_ab(1, "abcd", "efgh", "1234", "5678");
        bus_write(1, 0, 32'h6);
        bus_write(1, 1 + MB, 32'hDEAD_BEEF);
        bus_read(1, 1 + MB, v);
        check("busy_write_ignored", v, "1234");
        bus_read(1, 0, v);
        check("busy_mid_run", {31'd0, v[5]}, 32'd1);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        model_reset();
        for (int a = 0; a <= RES; a++) begin
            bus_read(1, a, v);
            check($sformatf("midrun_reset_addr%0d", a), v, 32'd0);
        end

        // Randomized operations on both instances.
        for (int it = 0; it < 40; it++) begin
            d = int'($urandom_range(0, 1));
            for (int k = 0; k < 2; k++)
                w[k] = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
            if ($urandom_range(0, 1) == 1) begin
                w[2] = w[0];
                w[3] = w[1];
                if ($urandom_range(0, 1) == 1)
                    w[2 + int'($urandom_range(0, 1))] ^= 32'h1 << (8 * $urandom_range(0, 3));
            end else begin
                w[2] = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
                w[3] = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
            end
            set_ab(d, w[0], w[1], w[2], w[3]);
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            do_op(d, op, clocks);
            if ($urandom_range(0, 3) == 0) begin
                bus_write(d, 0, 32'h0);
                bus_read(d, 0, v);
                check("rand_go0_idle", v & 32'h23, 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
